// File: rtl/chi_link_tx_crd_ctrl.sv
// rtl/chi_link_tx_crd_ctrl.sv - CHI TX link-activation handshake and per-channel L-credit control
module chi_link_tx_crd_ctrl #(
   parameter int NUM_CHN = 3,
   parameter int MAX_CRD = 15,
   parameter int CRD_W   = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     link_en,
   output logic                     txlinkactivereq,
   input  logic                     txlinkactiveack,
   output logic                     txsactive,
   input  logic [NUM_CHN-1:0]       lcrdv,
   input  logic [NUM_CHN-1:0]       flit_req,
   output logic [NUM_CHN-1:0]       flit_gnt,
   output logic [NUM_CHN-1:0]       lnk_flit_v,
   output logic [NUM_CHN-1:0]       flitpend,
   output logic [NUM_CHN*CRD_W-1:0] crd_cnt,
   output logic [1:0]               link_state,
   output logic [NUM_CHN-1:0]       crd_err,
   input  logic                     err_clr
);

   localparam logic [1:0] ST_STOP       = 2'b00;
   localparam logic [1:0] ST_ACTIVATE   = 2'b01;
   localparam logic [1:0] ST_RUN        = 2'b10;
   localparam logic [1:0] ST_DEACTIVATE = 2'b11;
   localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(MAX_CRD);
   localparam logic [CRD_W-1:0] CRD_ONE = CRD_W'(1);

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic               r_req;
   logic [CRD_W-1:0]   r_cnt [NUM_CHN];
   logic [NUM_CHN-1:0] r_err;
   logic [NUM_CHN-1:0] w_inc;
   logic [NUM_CHN-1:0] w_dec;
   logic [NUM_CHN-1:0] w_full;
   logic [NUM_CHN-1:0] w_nz;
   logic [NUM_CHN-1:0] w_err_set;
   logic               w_all_zero;

   always_comb begin
      w_inc      = '0;
      w_dec      = '0;
      w_full     = '0;
      w_nz       = '0;
      w_err_set  = '0;
      flit_gnt   = '0;
      lnk_flit_v = '0;
      flitpend   = '0;
      crd_cnt    = '0;
      for (int i = 0; i < NUM_CHN; i++) begin
         w_nz[i]       = (r_cnt[i] != '0);
         w_full[i]     = (r_cnt[i] == CRD_MAX);
         flit_gnt[i]   = (r_state == ST_RUN) & flit_req[i] & w_nz[i];
         lnk_flit_v[i] = (r_state == ST_DEACTIVATE) & w_nz[i];
         flitpend[i]   = (r_state == ST_ACTIVATE) | (r_state == ST_RUN) | lnk_flit_v[i];
         w_inc[i]      = lcrdv[i] & (r_state != ST_STOP);
         w_dec[i]      = flit_gnt[i] | lnk_flit_v[i];
         // Credits offered while the link is stopped are a protocol violation.
         w_err_set[i]  = (lcrdv[i] & (r_state == ST_STOP)) | (w_inc[i] & ~w_dec[i] & w_full[i]);
         crd_cnt[i*CRD_W +: CRD_W] = r_cnt[i];
      end
      w_all_zero = ~|w_nz;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_STOP:       if (link_en && !txlinkactiveack) w_state_nxt = ST_ACTIVATE;
         ST_ACTIVATE:   if (txlinkactiveack) w_state_nxt = ST_RUN;
         ST_RUN:        if (!link_en) w_state_nxt = ST_DEACTIVATE;
         default:       if (w_all_zero && !txlinkactiveack) w_state_nxt = ST_STOP;
      endcase
   end

   // REQ is decoded from the next state so it changes in the same cycle as link_state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_STOP;
         r_req   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= (w_state_nxt == ST_ACTIVATE) | (w_state_nxt == ST_RUN);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_CHN; i++) r_cnt[i] <= '0;
         r_err <= '0;
      end else begin
         for (int i = 0; i < NUM_CHN; i++) begin
            if (w_inc[i] && !w_dec[i] && !w_full[i])
               r_cnt[i] <= r_cnt[i] + CRD_ONE;
            else if (w_dec[i] && !w_inc[i])
               r_cnt[i] <= r_cnt[i] - CRD_ONE;
         end
         if (err_clr)
            r_err <= '0;
         else
            r_err <= r_err | w_err_set;
      end
   end

   assign txlinkactivereq = r_req;
   assign txsactive       = (r_state != ST_STOP) | (|flit_req);
   assign link_state      = r_state;
   assign crd_err         = r_err;

endmodule
